// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the M-extension operations
//   muldiv_state_e : control states IDLE / BUSY / DONE
//   DIV_ZERO_Q     : quotient returned on divide by zero
//   INT_MIN        : most negative 32-bit value (signed overflow operand/result)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
//   start, funct3, rs1_data, rs2_data, rd_addr, kill : requester -> unit
//   busy, result_valid, result, result_rd           : unit -> requester
// master: the requester (core / testbench); slave: muldiv_unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            kill;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr, kill,
    input  busy, result_valid, result, result_rd
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr, kill,
    output busy, result_valid, result, result_rd
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration on the shared 2*XLEN accumulator.
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_in  : multiply {partial_hi, multiplier_remaining}
//             divide   {remainder, dividend/quotient bits}
//   acc_out : accumulator after one step
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  // Multiply: add multiplicand into the high half when the next multiplier
  // bit is set, then shift the whole accumulator right including the carry.
  logic [XLEN:0] sum;
  assign sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);

  // Divide: the remainder shifted left with the next dividend bit can reach
  // XLEN+1 bits, so the trial comparison is done one bit wider. When it fits,
  // the true difference is below the divisor, so the low XLEN bits suffice.
  logic [XLEN:0]   partial;
  logic            fits;
  logic [XLEN-1:0] rem_sub;
  assign partial = acc_in[2*XLEN-1:XLEN-1];
  assign fits    = partial >= {1'b0, operand};
  assign rem_sub = partial[XLEN-1:0] - operand;

  always_comb begin
    acc_out = {sum, acc_in[XLEN-1:1]};
    if (is_div) begin
      if (fits) acc_out = {rem_sub, acc_in[XLEN-2:0], 1'b1};
      else      acc_out = {partial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : muldiv_if.slave -- start/funct3/operands/rd_addr/kill in,
//            busy/result_valid/result/result_rd out
// Operands are converted to magnitudes at start, iterated STEPS_PER_CYCLE
// radix-2 steps per BUSY cycle (legal: 1, 2, 4), and sign-corrected on the
// way into the result register. Divide-by-zero and signed overflow bypass
// the iteration and reach DONE one cycle after start.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int         ITER = XLEN / STEPS_PER_CYCLE;
  localparam logic [5:0] LAST = 6'(ITER - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [5:0]        count;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic              neg;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result;
  logic [4:0]        result_rd;

  // ---- request decode (used only when a start is accepted in IDLE) ----
  logic            in_div, in_rem, sgn1, sgn2, s1, s2;
  logic            div_zero, overflow;
  logic [XLEN-1:0] mag1, mag2, special_result;

  assign in_div = bus.funct3[2];
  assign in_rem = bus.funct3[2] & bus.funct3[1];
  assign sgn1   = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_MULHSU) ||
                  (bus.funct3 == OP_DIV)  || (bus.funct3 == OP_REM);
  assign sgn2   = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_DIV) ||
                  (bus.funct3 == OP_REM);
  assign s1     = sgn1 & bus.rs1_data[XLEN-1];
  assign s2     = sgn2 & bus.rs2_data[XLEN-1];
  assign mag1   = s1 ? -bus.rs1_data : bus.rs1_data;
  assign mag2   = s2 ? -bus.rs2_data : bus.rs2_data;

  assign div_zero = in_div && (bus.rs2_data == '0);
  assign overflow = in_div && !bus.funct3[0] &&
                    (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
  assign special_result = div_zero ? (in_rem ? bus.rs1_data : DIV_ZERO_Q)
                                   : (in_rem ? '0 : INT_MIN);

  // ---- step chain ----
  logic [2*XLEN-1:0] chain [STEPS_PER_CYCLE+1];
  assign chain[0] = acc;

  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[2]),
        .operand (operand),
        .acc_in  (chain[gi]),
        .acc_out (chain[gi+1])
      );
    end
  endgenerate

  // ---- sign correction and result select for the final BUSY cycle ----
  logic [2*XLEN-1:0] acc_final, prod;
  logic [XLEN-1:0]   div_val, final_result;

  assign acc_final = chain[STEPS_PER_CYCLE];

  always_comb begin
    prod    = neg ? -acc_final : acc_final;
    div_val = op[1] ? acc_final[2*XLEN-1:XLEN] : acc_final[XLEN-1:0];
    if (op[2])              final_result = neg ? -div_val : div_val;
    else if (op == OP_MUL)  final_result = prod[XLEN-1:0];
    else                    final_result = prod[2*XLEN-1:XLEN];
  end

  // ---- control and datapath registers ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      op        <= '0;
      rd        <= '0;
      neg       <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      result    <= '0;
      result_rd <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.kill) begin
            op      <= bus.funct3;
            rd      <= bus.rd_addr;
            count   <= '0;
            // Remainder takes the dividend's sign; everything else s1^s2.
            neg     <= in_rem ? s1 : (s1 ^ s2);
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            operand <= in_div ? mag2 : mag1;
            acc     <= {{XLEN{1'b0}}, in_div ? mag1 : mag2};
            if (div_zero || overflow) begin
              result    <= special_result;
              result_rd <= bus.rd_addr;
              state     <= ST_DONE;
            end else begin
              state     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (bus.kill) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            acc   <= acc_final;
            count <= count + 6'd1;
            if (count == LAST) begin
              count     <= '0;
              result    <= final_result;
              result_rd <= rd;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != ST_IDLE);
  assign bus.result_valid = (state == ST_DONE);
  assign bus.result       = result;
  assign bus.result_rd    = result_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit. Cycle 0 is the cycle in which
// start is presented; inputs change and outputs are sampled 1 time unit after
// the rising edge.
module tb_muldiv_unit;

  logic clock;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr  = rd;
  endtask

  // Issue one op in the current cycle and wait for its result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    drive(f3, a, b, rd);
    next_cycle();
    bus.start = 1'b0;
    lat = 1;
    check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
    while (!bus.result_valid && lat < 100) begin
      next_cycle();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_rd"}, 32'(bus.result_rd), 32'(rd));
    next_cycle();
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    $display("op %s f3=%0d rs1=0x%08h rs2=0x%08h -> result=0x%08h rd=%0d latency=%0d",
             tag, f3, a, b, bus.result, bus.result_rd, lat);
  endtask

  initial begin
    int pulses;
    int first_lat;
    logic [31:0] first_res;
    logic early_valid;

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.kill     = 1'b0;
    bus.funct3   = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr  = '0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_rd", 32'(bus.result_rd), 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    run_op("mul_neg",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
    run_op("mulh_m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 33);
    run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33);
    run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33);
    run_op("divu",      3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        33);
    run_op("remu",      3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         33);
    run_op("div_min2",  3'b100, 32'h8000_0000, 32'd2,         5'd14, 32'hC000_0000, 33);
    run_op("divu_z",    3'b101, 32'd100,       32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run_op("remu_z",    3'b111, 32'd100,       32'd0,         5'd16, 32'd100,       1);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1);

    // start re-asserted mid-operation must be ignored
    drive(3'b000, 32'd5, 32'd6, 5'd20);
    next_cycle();
    bus.start = 1'b0;
    pulses = 0;
    first_lat = 0;
    first_res = '0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) drive(3'b000, 32'd9, 32'd9, 5'd21);
      if (c == 11) bus.start = 1'b0;
      if (bus.result_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_lat = c;
          first_res = bus.result;
        end
      end
      next_cycle();
    end
    check("restart_pulses", 32'(pulses), 32'd1);
    check("restart_latency", 32'(first_lat), 32'd33);
    check("restart_result", first_res, 32'd30);
    $display("op restart_ignored pulses=%0d latency=%0d result=0x%08h", pulses, first_lat, first_res);

    // kill in cycle 10 aborts; a new op is accepted in cycle 11
    drive(3'b000, 32'd11, 32'd11, 5'd22);
    next_cycle();
    bus.start = 1'b0;
    early_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.result_valid) early_valid = 1'b1;
      if (c == 10) bus.kill = 1'b1;
      if (c < 10) next_cycle();
    end
    check("kill_valid_c10", 32'(bus.result_valid), 32'd0);
    next_cycle();
    bus.kill = 1'b0;
    check("kill_busy_c11", 32'(bus.busy), 32'd0);
    check("kill_no_result", 32'(early_valid | bus.result_valid), 32'd0);
    $display("op kill busy_c11=%0d", bus.busy);
    run_op("after_kill", 3'b000, 32'd3, 32'd5, 5'd23, 32'd15, 33);

    // asynchronous reset in cycle 15 of an operation
    drive(3'b000, 32'd9, 32'd9, 5'd24);
    next_cycle();
    bus.start = 1'b0;
    for (int c = 1; c < 15; c++) next_cycle();
    reset = 1'b0;
    #1;
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_valid", 32'(bus.result_valid), 32'd0);
    check("areset_result", bus.result, 32'd0);
    check("areset_rd", 32'(bus.result_rd), 32'd0);
    $display("op async_reset busy=%0d valid=%0d result=0x%08h rd=%0d",
             bus.busy, bus.result_valid, bus.result, bus.result_rd);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    run_op("post_reset", 3'b000, 32'd3, 32'd4, 5'd25, 32'd12, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
